mux_n1_rr: RTL and testbench

MUX_N1_RR -- requirements
Module: mux_n1_rr

---
 rtl/mux_n1_rr_if.sv | 29 ++
 rtl/mux_n1_rr.sv | 90 +++++++++
 tb/tb_mux_n1_rr.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mux_n1_rr_if.sv
// Channel bundle for the N:1 multiplexer: N upstream valid/ready channels
// plus mode/select controls on one side, one registered output on the other.
interface mux_n1_rr_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
);
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_chan;
    logic           out_valid;
    logic           out_ready;

    // Multiplexer side
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    // Producer/consumer side
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_n1_rr.sv
// N:1 valid/ready multiplexer with manual or round-robin channel selection
// and a single registered output stage that sustains one word per cycle.
module mux_n1_rr #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        rst,
    mux_n1_rr_if.slave  bus
);
    localparam int SW = $clog2(N);

    logic [W-1:0]  out_data_reg;
    logic [SW-1:0] out_chan_reg;
    logic          out_valid_reg;
    logic [SW-1:0] ptr_reg;
    logic [SW-1:0] ptr_next;

    logic          load_en;
    logic          grant_vld;
    logic [SW-1:0] grant_idx;
    logic [N-1:0]  in_ready_w;

    // The output register can take a new word when empty or being drained.
    assign load_en = !out_valid_reg || bus.out_ready;

    // Grant decision: manual select, or first valid channel from ptr upward.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (!bus.mode) begin
            // A select value with no matching channel simply yields no grant.
            for (int i = 0; i < N; i++) begin
                if (bus.sel == SW'(i) && bus.in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SW'(i);
                end
            end
        end else begin
            // Walk the search order backwards so the closest hit to ptr wins.
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(ptr_reg) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (bus.in_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = SW'(idx);
                end
            end
        end
    end

    assign ptr_next = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);

    // At most one ready bit, and none while reset is held.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign in_ready_w[gi] = !rst && load_en && grant_vld && (grant_idx == SW'(gi));
        end
    endgenerate

    // Output register and round-robin pointer; a transfer is a grant with load_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            out_valid_reg <= 1'b0;
            ptr_reg       <= '0;
        end else if (load_en) begin
            if (grant_vld) begin
                out_data_reg  <= bus.in_data[int'(grant_idx)*W +: W];
                out_chan_reg  <= grant_idx;
                out_valid_reg <= 1'b1;
                if (bus.mode) begin
                    ptr_reg <= ptr_next;
                end
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_data  = out_data_reg;
    assign bus.out_chan  = out_chan_reg;
    assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_mux_n1_rr.sv
// Directed bench for mux_n1_rr: stimulus pushes expected words into a
// scoreboard queue, a negedge monitor pops them as the output drains.
module tb_mux_n1_rr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_n1_rr_if #(.N(4), .W(8)) bus ();
    mux_n1_rr_if #(.N(5), .W(8)) bus5 ();

    mux_n1_rr #(.N(4), .W(8)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    mux_n1_rr #(.N(5), .W(8)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

    int total = 0;
    int bad   = 0;
    int seq   = 0;
    logic [9:0] sb[$];
    logic [7:0] held;

    function automatic logic [7:0] dval(input int s, input int ch);
        return 8'((s * 16 + ch) & 255);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // One cycle on the N=4 instance: drive at posedge+1, check ready, record
    // the expected word, then advance to the next posedge+1.
    task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic r, input logic [3:0] er);
        seq++;
        bus.mode      = m;
        bus.sel       = s;
        bus.in_valid  = v;
        bus.out_ready = r;
        for (int i = 0; i < 4; i++) bus.in_data[i*8 +: 8] = dval(seq, i);
        #3;
        chk("in_ready", 64'(bus.in_ready), 64'(er));
        for (int i = 0; i < 4; i++) begin
            if (er[i]) sb.push_back({2'(i), dval(seq, i)});
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: a word leaves whenever out_valid and out_ready meet at an edge.
    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word actual=%0h/%0h required=none",
                         bus.out_chan, bus.out_data);
            end else begin
                e = sb.pop_front();
                chk("sb_out_chan", 64'(bus.out_chan), 64'(e[9:8]));
                chk("sb_out_data", 64'(bus.out_data), 64'(e[7:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mode = 1'b1; bus.sel = '0; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        bus.in_data = 32'h44332211;
        bus5.mode = 1'b0; bus5.sel = '0; bus5.in_valid = '0; bus5.out_ready = 1'b1;
        bus5.in_data = 40'h5544332211;

        // Reset state, with requests pending
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_out_chan", 64'(bus.out_chan), 64'h0);
        chk("rst_out_data", 64'(bus.out_data), 64'h0);
        chk("rst_ptr", 64'(dut.ptr_reg), 64'h0);
        rst = 1'b0;

        // Manual select of channel 2
        for (int c = 0; c < 4; c++) step(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100);
        chk("manual_ptr", 64'(dut.ptr_reg), 64'h0);

        // Round-robin, all channels requesting, continuous output
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 2'd0, 4'b1111, 1'b1, 4'(1 << (c % 4)));
            chk("rr_out_valid", 64'(bus.out_valid), 64'h1);
        end

        // Round-robin on channels 1 and 3: ptr 2,0,2,0
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 2'd0, 4'b1010, 1'b1, (c % 2 == 0) ? 4'b0010 : 4'b1000);
            chk("rr_ptr", 64'(dut.ptr_reg), (c % 2 == 0) ? 64'h2 : 64'h0);
        end

        // Backpressure on a ch1 word
        step(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010);
        held = dval(seq, 1);
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 2'd0, 4'b0010, 1'b0, 4'b0000);
            chk("bp_out_valid", 64'(bus.out_valid), 64'h1);
            chk("bp_out_chan", 64'(bus.out_chan), 64'h1);
            chk("bp_out_data", 64'(bus.out_data), 64'(held));
        end
        step(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010);
        held = dval(seq, 1);
        chk("bp_reload_data", 64'(bus.out_data), 64'(held));

        // Manual select of a non-requesting channel: word drains, fields hold
        step(1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000);
        chk("nogrant_out_valid", 64'(bus.out_valid), 64'h0);
        chk("nogrant_out_chan", 64'(bus.out_chan), 64'h1);
        chk("nogrant_out_data", 64'(bus.out_data), 64'(held));
        step(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000);
        chk("idle_ptr", 64'(dut.ptr_reg), 64'h2);

        // N=5 instance: select values 5 and 7 have no channel
        bus5.sel = 3'd0; bus5.in_valid = 5'b11111; bus5.out_ready = 1'b1;
        #3;
        chk("n5_in_ready_sel0", 64'(bus5.in_ready), 64'h01);
        @(posedge clk); #1;
        chk("n5_load_valid", 64'(bus5.out_valid), 64'h1);
        chk("n5_load_data", 64'(bus5.out_data), 64'h11);
        bus5.sel = 3'd5; bus5.out_ready = 1'b0;
        #3;
        chk("n5_in_ready_sel5", 64'(bus5.in_ready), 64'h0);
        @(posedge clk); #1;
        chk("n5_hold_valid", 64'(bus5.out_valid), 64'h1);
        bus5.sel = 3'd7; bus5.out_ready = 1'b1;
        #3;
        chk("n5_in_ready_sel7", 64'(bus5.in_ready), 64'h0);
        @(posedge clk); #1;
        chk("n5_drain_valid", 64'(bus5.out_valid), 64'h0);
        chk("n5_drain_chan", 64'(bus5.out_chan), 64'h0);
        chk("n5_drain_data", 64'(bus5.out_data), 64'h11);

        // Reset while a word is held and a transfer is pending
        step(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0100);
        chk("pre_rst_ptr", 64'(dut.ptr_reg), 64'h3);
        step(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000);
        rst = 1'b1;
        #3;
        chk("rst_mid_in_ready", 64'(bus.in_ready), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        chk("rst_mid_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_mid_out_chan", 64'(bus.out_chan), 64'h0);
        chk("rst_mid_out_data", 64'(bus.out_data), 64'h0);
        step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001);
        chk("post_rst_ptr", 64'(dut.ptr_reg), 64'h1);

        // Drain and confirm every expected word appeared
        step(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000);
        step(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000);
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
